// File: rtl/pipe_chk.sv
// pipe_chk: response checker for the (a + b) * (c - d) arithmetic pipeline.
// It captures each issued operand set and computes the expected result. The
// expected value is carried through a LAT-deep delay line and compared with
// the pipeline output f. Define PIPE_CHK_STOP_EN to make the checker halt on
// the first mismatch and freeze its state until clr or reset.
module pipe_chk #(
  parameter int W   = 10,
  parameter int LAT = 3,
  parameter int CW  = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  input  logic [W-1:0]  a,
  input  logic [W-1:0]  b,
  input  logic [W-1:0]  c,
  input  logic [W-1:0]  d,
  input  logic [W-1:0]  f,
  input  logic          clr,
  output logic          chk_valid,
  output logic          mismatch,
  output logic [W-1:0]  exp_f,
  output logic [CW-1:0] pass_cnt,
  output logic [CW-1:0] err_cnt,
  output logic          err_sticky,
  output logic          busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1
`ifdef PIPE_CHK_STOP_EN
    ,
    ST_HALT = 2'd2
`endif
  } state_e;

  localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [W-1:0]  DAT_ZERO = {W{1'b0}};

  // Golden model: every intermediate wraps modulo 2^W.
  function automatic logic [W-1:0] golden(
    input logic [W-1:0] ga,
    input logic [W-1:0] gb,
    input logic [W-1:0] gc,
    input logic [W-1:0] gd
  );
    logic [W-1:0] sum_v;
    logic [W-1:0] dif_v;
    sum_v  = ga + gb;
    dif_v  = gc - gd;
    golden = sum_v * dif_v;
  endfunction

  // Delay line: one {vld, exp} slot per pipeline stage.
  logic [LAT-1:0] vld_q;
  logic [LAT-1:0] vld_d;
  logic [LAT-1:0] vld_shift_s;
  logic [W-1:0]   exp_q [LAT];
  logic [W-1:0]   exp_d [LAT];

  logic           chk_valid_q, chk_valid_d;
  logic           mismatch_q, mismatch_d;
  logic [W-1:0]   exp_f_q, exp_f_d;
  logic [CW-1:0]  pass_q, pass_d;
  logic [CW-1:0]  err_q, err_d;
  logic           sticky_q, sticky_d;
  logic           busy_q;
  state_e         state_q, state_d;

  logic [W-1:0]   exp_in_s;
  logic           cmp_s;
  logic           fail_s;
  logic           empty_s;
  logic           halt_s;
  logic           stop_s;
  logic           flush_s;

  assign exp_in_s = golden(a, b, c, d);
  assign cmp_s    = vld_q[LAT-1];
  assign fail_s   = cmp_s && (f != exp_q[LAT-1]);
  assign empty_s  = ~|vld_q;

`ifdef PIPE_CHK_STOP_EN
  assign halt_s = (state_q == ST_HALT);
  assign stop_s = fail_s;
`else
  assign halt_s = 1'b0;
  assign stop_s = 1'b0;
`endif

  // A failing compare in stop mode also discards the rest of the stream.
  assign flush_s = clr || halt_s || stop_s;

  // Delay-line shift; stage 0 captures the new sample, a flush drops everything.
  always_comb begin
    vld_shift_s[0] = in_valid;
    exp_d[0]       = exp_in_s;
    for (int i = 1; i < LAT; i++) begin
      vld_shift_s[i] = vld_q[i-1];
      exp_d[i]       = exp_q[i-1];
    end
    if (flush_s) begin
      vld_d = {LAT{1'b0}};
    end else begin
      vld_d = vld_shift_s;
    end
  end

  // Compare result, saturating counters and sticky error flag.
  always_comb begin
    chk_valid_d = 1'b0;
    mismatch_d  = 1'b0;
    exp_f_d     = exp_f_q;
    pass_d      = pass_q;
    err_d       = err_q;
    sticky_d    = sticky_q;
    if (clr) begin
      exp_f_d  = DAT_ZERO;
      pass_d   = CNT_ZERO;
      err_d    = CNT_ZERO;
      sticky_d = 1'b0;
    end else if (halt_s) begin
      exp_f_d = exp_f_q;
    end else if (cmp_s) begin
      chk_valid_d = 1'b1;
      mismatch_d  = fail_s;
      exp_f_d     = exp_q[LAT-1];
      if (fail_s) begin
        sticky_d = 1'b1;
        if (err_q != CNT_MAX) begin
          err_d = err_q + CNT_ONE;
        end else begin
          err_d = err_q;
        end
      end else begin
        if (pass_q != CNT_MAX) begin
          pass_d = pass_q + CNT_ONE;
        end else begin
          pass_d = pass_q;
        end
      end
    end else begin
      chk_valid_d = 1'b0;
    end
  end

  // Control FSM: IDLE while nothing is in flight, RUN otherwise, HALT in stop mode.
  always_comb begin
    state_d = state_q;
    if (clr) begin
      state_d = ST_IDLE;
`ifdef PIPE_CHK_STOP_EN
    end else if (halt_s || fail_s) begin
      state_d = ST_HALT;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid || !empty_s) begin
            state_d = ST_RUN;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_RUN: begin
          if (empty_s && !in_valid) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_RUN;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State and output registers; reset discards all in-flight tokens.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q       <= {LAT{1'b0}};
      for (int i = 0; i < LAT; i++) begin
        exp_q[i] <= DAT_ZERO;
      end
      chk_valid_q <= 1'b0;
      mismatch_q  <= 1'b0;
      exp_f_q     <= DAT_ZERO;
      pass_q      <= CNT_ZERO;
      err_q       <= CNT_ZERO;
      sticky_q    <= 1'b0;
      busy_q      <= 1'b0;
      state_q     <= ST_IDLE;
    end else begin
      vld_q       <= vld_d;
      for (int i = 0; i < LAT; i++) begin
        exp_q[i] <= exp_d[i];
      end
      chk_valid_q <= chk_valid_d;
      mismatch_q  <= mismatch_d;
      exp_f_q     <= exp_f_d;
      pass_q      <= pass_d;
      err_q       <= err_d;
      sticky_q    <= sticky_d;
      busy_q      <= (state_d == ST_RUN);
      state_q     <= state_d;
    end
  end

  assign chk_valid  = chk_valid_q;
  assign mismatch   = mismatch_q;
  assign exp_f      = exp_f_q;
  assign pass_cnt   = pass_q;
  assign err_cnt    = err_q;
  assign err_sticky = sticky_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_pipe_chk.sv
// tb_pipe_chk: directed bench for pipe_chk. A LAT-deep shift register stands
// in for the arithmetic pipeline and replays hand-computed results on f.
// A second instance with CW=4 covers counter saturation.
module tb_pipe_chk;
  localparam int W   = 10;
  localparam int LAT = 3;
  localparam int CW  = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          clr;
  logic [W-1:0]  a, b, c, d, f, f_in;
  logic [W-1:0]  fp [LAT];

  logic          chk_valid, mismatch, err_sticky, busy;
  logic [W-1:0]  exp_f;
  logic [CW-1:0] pass_cnt, err_cnt;

  logic          chk_valid_s, mismatch_s, err_sticky_s, busy_s;
  logic [W-1:0]  exp_f_s;
  logic [3:0]    pass_cnt_s, err_cnt_s;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int t0;
  int q_cyc[$];
  int q_exp[$];
  int q_mis[$];
  int q_stk[$];

  pipe_chk #(.W(W), .LAT(LAT), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .a(a), .b(b), .c(c), .d(d), .f(f), .clr(clr),
    .chk_valid(chk_valid), .mismatch(mismatch), .exp_f(exp_f),
    .pass_cnt(pass_cnt), .err_cnt(err_cnt), .err_sticky(err_sticky), .busy(busy)
  );

  pipe_chk #(.W(W), .LAT(LAT), .CW(4)) dut_s (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .a(a), .b(b), .c(c), .d(d), .f(f), .clr(clr),
    .chk_valid(chk_valid_s), .mismatch(mismatch_s), .exp_f(exp_f_s),
    .pass_cnt(pass_cnt_s), .err_cnt(err_cnt_s), .err_sticky(err_sticky_s), .busy(busy_s)
  );

  always #5 clk = ~clk;

  // Pipeline stand-in: the result supplied with a sample appears on f LAT edges later.
  always @(posedge clk) begin
    fp[0] <= f_in;
    for (int i = 1; i < LAT; i++) fp[i] <= fp[i-1];
  end
  assign f = fp[LAT-1];

  task automatic check_eq(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // One clock; log every chk_valid cycle with its cycle number.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    cyc++;
    if (chk_valid) begin
      q_cyc.push_back(cyc);
      q_exp.push_back(int'(exp_f));
      q_mis.push_back(int'(mismatch));
      q_stk.push_back(int'(err_sticky));
    end
  endtask

  task automatic drive(input logic v, input int ai, input int bi, input int ci,
                       input int di, input int fi);
    in_valid = v;
    a        = ai[W-1:0];
    b        = bi[W-1:0];
    c        = ci[W-1:0];
    d        = di[W-1:0];
    f_in     = fi[W-1:0];
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic clear_q();
    q_cyc.delete();
    q_exp.delete();
    q_mis.delete();
    q_stk.delete();
  endtask

  task automatic pulse_clr();
    clr      = 1'b1;
    in_valid = 1'b0;
    tick();
    clr      = 1'b0;
    clear_q();
  endtask

  initial begin
    rst_n = 1'b0; clr = 1'b0;
    drive(1'b0, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    check_eq("rst_chk_valid", chk_valid, 0);
    check_eq("rst_exp_f", exp_f, 0);
    check_eq("rst_pass", pass_cnt, 0);
    check_eq("rst_err", err_cnt, 0);
    check_eq("rst_sticky", err_sticky, 0);
    check_eq("rst_busy", busy, 0);
    rst_n = 1'b1;
    tick();

    // Back-to-back stream, all correct.
    clear_q();
    t0 = cyc;
    drive(1'b1, 5, 12, 6, 3, 51);   tick();
    check_eq("t1_busy_rise", busy, 1);
    drive(1'b1, 10, 8, 5, 2, 54);   tick();
    drive(1'b1, 20, 11, 1, 4, 931); tick();
    drive(1'b1, 15, 10, 8, 2, 150); tick();
    idle(6);
    check_eq("t1_nchk", q_exp.size(), 4);
    for (int i = 0; i < 4; i++) begin
      check_eq("t1_cyc", (i < q_cyc.size()) ? q_cyc[i] : -1, t0 + LAT + 1 + i);
      check_eq("t1_mis", (i < q_mis.size()) ? q_mis[i] : -1, 0);
    end
    check_eq("t1_exp0", (q_exp.size() > 0) ? q_exp[0] : -1, 51);
    check_eq("t1_exp1", (q_exp.size() > 1) ? q_exp[1] : -1, 54);
    check_eq("t1_exp2", (q_exp.size() > 2) ? q_exp[2] : -1, 931);
    check_eq("t1_exp3", (q_exp.size() > 3) ? q_exp[3] : -1, 150);
    check_eq("t1_pass", pass_cnt, 4);
    check_eq("t1_err", err_cnt, 0);
    check_eq("t1_sticky", err_sticky, 0);
    check_eq("t1_busy_fall", busy, 0);

    // Same stream with the second result corrupted to 55.
    pulse_clr();
    drive(1'b1, 5, 12, 6, 3, 51);   tick();
    drive(1'b1, 10, 8, 5, 2, 55);   tick();
    drive(1'b1, 20, 11, 1, 4, 931); tick();
    drive(1'b1, 15, 10, 8, 2, 150); tick();
    idle(6);
    check_eq("t2_mis0", (q_mis.size() > 0) ? q_mis[0] : -1, 0);
    check_eq("t2_mis1", (q_mis.size() > 1) ? q_mis[1] : -1, 1);
    check_eq("t2_exp1", (q_exp.size() > 1) ? q_exp[1] : -1, 54);
    check_eq("t2_stk0", (q_stk.size() > 0) ? q_stk[0] : -1, 0);
    check_eq("t2_stk1", (q_stk.size() > 1) ? q_stk[1] : -1, 1);
    check_eq("t2_err", err_cnt, 1);
    check_eq("t2_sticky", err_sticky, 1);
`ifdef PIPE_CHK_STOP_EN
    check_eq("t2_nchk", q_exp.size(), 2);
    check_eq("t2_pass", pass_cnt, 1);
    check_eq("t2_halt_exp_f", exp_f, 54);
    check_eq("t2_halt_chk", chk_valid, 0);
`else
    check_eq("t2_nchk", q_exp.size(), 4);
    check_eq("t2_mis2", (q_mis.size() > 2) ? q_mis[2] : -1, 0);
    check_eq("t2_mis3", (q_mis.size() > 3) ? q_mis[3] : -1, 0);
    check_eq("t2_pass", pass_cnt, 3);
`endif

    // Sparse issue on relative cycles 0, 2 and 5.
    pulse_clr();
    t0 = cyc;
    for (int k = 0; k < 6; k++) begin
      case (k)
        0:       drive(1'b1, 1, 2, 3, 1, 6);
        2:       drive(1'b1, 7, 0, 2, 0, 14);
        5:       drive(1'b1, 100, 200, 10, 7, 900);
        default: drive(1'b0, 0, 0, 0, 0, 0);
      endcase
      tick();
    end
    idle(6);
    check_eq("t3_nchk", q_exp.size(), 3);
    check_eq("t3_cyc0", (q_cyc.size() > 0) ? q_cyc[0] : -1, t0 + LAT + 1);
    check_eq("t3_cyc1", (q_cyc.size() > 1) ? q_cyc[1] : -1, t0 + LAT + 3);
    check_eq("t3_cyc2", (q_cyc.size() > 2) ? q_cyc[2] : -1, t0 + LAT + 6);
    check_eq("t3_exp2", (q_exp.size() > 2) ? q_exp[2] : -1, 900);
    check_eq("t3_pass", pass_cnt, 3);

    // Asynchronous reset with two tokens in flight.
    clear_q();
    drive(1'b1, 5, 12, 6, 3, 51); tick();
    drive(1'b1, 10, 8, 5, 2, 54); tick();
    in_valid = 1'b0;
    check_eq("t4_busy_pre", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("t4_rst_pass", pass_cnt, 0);
    check_eq("t4_rst_exp_f", exp_f, 0);
    check_eq("t4_rst_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(6);
    check_eq("t4_late_chk", q_exp.size(), 0);

    // clr together with in_valid after three passes.
    pulse_clr();
    drive(1'b1, 5, 12, 6, 3, 51);   tick();
    drive(1'b1, 10, 8, 5, 2, 54);   tick();
    drive(1'b1, 20, 11, 1, 4, 931); tick();
    idle(5);
    check_eq("t5_pass_pre", pass_cnt, 3);
    drive(1'b1, 15, 10, 8, 2, 150);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    in_valid = 1'b0;
    check_eq("t5_pass", pass_cnt, 0);
    check_eq("t5_err", err_cnt, 0);
    check_eq("t5_busy", busy, 0);
    clear_q();
    idle(6);
    check_eq("t5_dropped", q_exp.size(), 0);

    // Saturation: 20 correct samples into the 4-bit counter instance.
    pulse_clr();
    for (int i = 1; i <= 20; i++) begin
      drive(1'b1, i, 0, 1, 0, i);
      tick();
    end
    idle(6);
    check_eq("t6_pass16", pass_cnt, 20);
    check_eq("t6_pass_sat", pass_cnt_s, 15);
    check_eq("t6_err_sat", err_cnt_s, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_chk.md
# pipe_chk

Synthesizable response checker for the arithmetic datapath pipeline. It sits on the opposite end of the pipeline's stimulus interface. It captures each operand set as it is issued, computes the expected result with a golden model, and delays it by the pipeline latency. It then compares the result against the pipeline output `f` and reports per-sample pass/fail, running counts and a sticky error flag. It is used both in simulation benches and as an on-chip self-check next to the pipeline.

## Interface
Parameters:
- `W`, 10, operand and result width in bits.
- `LAT`, 3, pipeline latency in clock cycles from operand sample to valid `f` (legal range 1–8).
- `CW`, 16, width of the pass and error counters.

Ports:
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `in_valid` input 1: operands on `a`..`d` are being issued to the pipeline this cycle.
- `a`, `b`, `c`, `d` input W each: operands, the same values driven into the pipeline.
- `f` input W: pipeline result.
- `clr` input 1: synchronous clear of counters, sticky flag and in-flight tokens.
- `chk_valid` output 1: a comparison completed this cycle.
- `mismatch` output 1: the comparison flagged by `chk_valid` failed.
- `exp_f` output W: expected value used in the current comparison.
- `pass_cnt` output CW: number of passing comparisons, saturating.
- `err_cnt` output CW: number of failing comparisons, saturating.
- `err_sticky` output 1: set by any mismatch, cleared only by reset or `clr`.
- `busy` output 1: at least one token is in flight.

## Operation
- Golden model: `exp = (a + b) * (c - d)`, evaluated modulo 2^W. All intermediate sums and differences are taken modulo 2^W, two's-complement wrap, with no saturation.
  - Example: a=20, b=11, c=1, d=4 gives exp = 31 * (−3) mod 1024 = 931.
- Delay line has LAT stages. Each stage holds `{vld, exp}`.
  - Stage 0 loads `{in_valid, exp}` on every edge.
  - Each later stage shifts from the previous stage.
  - Slots with `vld=0` carry no comparison.
- Compare: when the last stage's `vld` is 1, its `exp` is compared with the `f` sampled on that same edge. The result is registered into `chk_valid`, `mismatch`, `exp_f` and the counters.
- Counters increment by 1 per comparison and hold at 2^CW−1 (saturate, never wrap).
- FSM, 3 states:
  - IDLE: no tokens in flight, `busy=0`. Goes to RUN on `in_valid`.
  - RUN: tokens in flight, `busy=1`. Goes to IDLE when the delay line is empty and `in_valid=0`.
  - HALT: only when `PIPE_CHK_STOP_EN` is defined (see Configuration).
- `clr` flushes the delay line, zeroes the counters, clears `err_sticky`, and forces IDLE.
  - If `in_valid` is high in the same cycle as `clr`, that sample is dropped.
- Back-to-back `in_valid` is fully supported: one comparison per cycle at steady state, with no bubbles inserted.

## Timing
- Reset values: all delay-line bits 0, `chk_valid=0`, `mismatch=0`, `exp_f=0`, `pass_cnt=0`, `err_cnt=0`, `err_sticky=0`, `busy=0`, state IDLE.
- Reset asserted mid-stream discards all in-flight tokens immediately, asynchronously.
- Sample taken on edge N with `in_valid=1`:
  - it is compared against `f` at edge N+LAT;
  - `chk_valid` is high for exactly the one cycle following edge N+LAT.
- `mismatch` and `exp_f` are valid only while `chk_valid=1`. `mismatch` is 0 whenever `chk_valid=0`.
- `err_sticky` rises in the same cycle as the first `mismatch`. Counters update in the same cycle as `chk_valid`.
- `busy` is registered: it is high from the cycle after the first `in_valid` edge until the cycle after the last token's compare edge.

## Configuration
- `PIPE_CHK_STOP_EN` defined:
  - On the first mismatch, the FSM enters HALT.
  - In HALT: `exp_f` holds the failing expected value, counters freeze, `chk_valid` stays 0, and further `in_valid` is ignored.
  - HALT exits only through `clr` or reset.
- `PIPE_CHK_STOP_EN` undefined: there is no HALT state. Checking continues and every mismatch is counted.

## Test plan
- Reset, then 4 vectors spaced 1 per cycle: (5,12,6,3), (10,8,5,2), (20,11,1,4), (15,10,8,2), with a correct model driving `f`.
  - Required: `exp_f` = 51, 54, 931, 150 on consecutive `chk_valid` cycles, starting LAT cycles after the first issue.
  - Required: `pass_cnt=4`, `err_cnt=0`, `err_sticky=0`, `busy` returns to 0.
- Same 4 vectors, but the model corrupts the 2nd result to 55.
  - Without the macro: `mismatch` only on the 2nd check, `err_cnt=1`, `pass_cnt=3`, `err_sticky=1`.
  - With `PIPE_CHK_STOP_EN`: HALT holding `exp_f=54`, `pass_cnt=1`, no further `chk_valid`.
- Sparse issue: `in_valid` high on cycles 0, 2, 5.
  - Required: exactly 3 `chk_valid` pulses, at cycles 0+LAT, 2+LAT and 5+LAT (plus the registered output delay), with no spurious checks.
- Reset mid-stream: assert `rst_n=0` with 2 tokens in flight.
  - Required: all outputs return to 0 immediately and no late `chk_valid` appears after reset release.
- `clr` together with `in_valid`, after 3 passes.
  - Required: counters read 0 on the next cycle, the concurrent sample produces no check, and `busy=0`.
- Saturation with CW=4: 20 correct samples.
  - Required: `pass_cnt` holds at 15.
